dmem_mmio: RTL and testbench
============================

# dmem_mmio

Data-side memory subsystem that sits directly downstream of the single-cycle RV32 CPU's data port and consumes its `daddr`/`dwdata`/`dwe` outputs. It returns `drdata` combinationally, so loads complete in the CPU's single cycle. It contains:
- a byte-writable word RAM;
- a small memory-mapped I/O window with a console transmit FIFO (valid/ready stream out), a status register and a free-running cycle counter.

## Interface
Parameters:
- `DEPTH`, 1024, RAM size in 32-bit words (power of two).
- `MMIO_BASE`, 32'hFFFF_0000, byte address of the 16-byte MMIO window.
- `TX_DEPTH`, 8, console FIFO entries (power of two, ≤ 8).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `daddr`  in  32  byte address from CPU.
- `dwdata`  in  32  write data from CPU, lane-aligned.
- `dwe`  in  4  byte-lane write enables; `dwe[i]` writes byte `i`.
- `drdata`  out  32  read data, combinational from `daddr`.
- `tx_data`  out  8  console byte at FIFO head.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  sink accepts `tx_data` this cycle.

## Operation
- **Address decode:**
  - RAM when `daddr < 4*DEPTH`, word index `daddr[log2(DEPTH)+1:2]`.
  - MMIO when `daddr[31:4] == MMIO_BASE[31:4]`, register offset `daddr[3:2]`.
  - Anything else: `drdata = 0`, writes ignored.
- **RAM:**
  - Each lane with `dwe[i]=1` writes `dwdata[8i+7:8i]` at the edge.
  - Read is asynchronous.
  - Contents are not cleared by reset.
- **MMIO offset 0x0, TXDATA:**
  - Write with `dwe[0]=1` pushes `dwdata[7:0]`.
  - Reads return 0.
- **MMIO offset 0x4, STATUS (read):**
  - bit0 empty, bit1 full, bit2 overflow (sticky), bits[7:4] occupancy count, other bits 0.
  - Write with `dwe[0]=1` and `dwdata[2]=1` clears overflow.
- **MMIO offset 0x8, CYCLE:**
  - Increments by 1 every cycle out of reset; wraps 0xFFFF_FFFF → 0.
  - A write with `dwe==4'b1111` loads `dwdata`; any other `dwe` is ignored.
- **MMIO offset 0xC:** reserved; reads 0, writes ignored.
- **FIFO:**
  - Pop when `tx_valid && tx_ready`.
  - Push accepted when not full, or when full with a pop in the same cycle (count unchanged).
  - Push while full with no pop: data dropped, overflow set.
  - Simultaneous push and pop when empty: the push is accepted, there is no pop (`tx_valid` was 0), and count becomes 1.
- **tx_data:** equals the head entry when non-empty, and 0 when empty.

## Timing
- Reset values:
  - `tx_valid=0`, `tx_data=0`, count 0, overflow 0, CYCLE 0.
  - `drdata` at the STATUS address reads `32'h0000_0001`.
- Reset asserted mid-operation: FIFO pointers, count, overflow and CYCLE clear immediately (asynchronous). RAM contents are held.
- Read latency: 0 cycles; `drdata` follows `daddr` combinationally within the same cycle.
- Write latency: visible from the cycle after the edge.
  - Push at edge N → `tx_valid=1` in cycle N+1.
  - CYCLE loaded with V at edge N reads V in N+1 and V+1 in N+2.
- **Handshake:**
  - `tx_data` is stable while `tx_valid && !tx_ready`.
  - `tx_valid` never drops without a pop.
  - No combinational path from `tx_ready` to `tx_valid`.
- Pointers wrap modulo `TX_DEPTH`; count saturates in the range 0..`TX_DEPTH`.

## Structure
- **Shared package `dmem_mmio_pkg`:**
  - Offsets `OFF_TXDATA`=0, `OFF_STATUS`=1, `OFF_CYCLE`=2 (word offsets).
  - STATUS bit positions `ST_EMPTY`, `ST_FULL`, `ST_OVF`, `ST_CNT_LSB`.
  - Default `MMIO_BASE`.
- **Sub-module `mmio_tx_fifo`:** synchronous FIFO.
  - Ports: push/push_data, pop, full/empty/count, head.
  - Holds the FIFO storage, pointers, count and full/empty logic.
- **Top level:** decode, RAM, CYCLE, overflow flag and `drdata` mux.

## Test plan
- Reset, then read STATUS → `32'h1`. Read CYCLE twice one cycle apart → 0 then 1. `tx_valid=0`.
- RAM byte lanes: `SW 0x11223344` @0x10, then `dwe=4'b0100` with `dwdata=32'h00AA_0000` → read @0x10 = `32'h11AA_3344`. Read @`4*DEPTH` → 0.
- Push 0x41, 0x42, 0x43 with `tx_ready=0` → STATUS = `32'h30`, `tx_data=0x41` held. Raise `tx_ready` → 0x41, 0x42, 0x43 on consecutive cycles, then `tx_valid=0`.
- Push 9 bytes with `tx_ready=0` → STATUS = `32'h86`. Write STATUS with `dwdata=4` → `32'h82`. Push while full with `tx_ready=1` → accepted, count stays 8, overflow stays 0.
- Write CYCLE = `32'hFFFF_FFFE` → reads FFFF_FFFE, FFFF_FFFF, 0 on successive cycles. Write with `dwe=4'b0011` → ignored.
- Assert `reset` low with the FIFO half full → `tx_valid` falls without waiting for a clock edge; after release, STATUS = 1 and previously written RAM data is intact.

Source files
------------

// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the data-side memory subsystem: MMIO register map,
// STATUS bit layout, address-region type and the STATUS word packing helper.
package dmem_mmio_pkg;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_0000;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CYCLE  = 2'd2;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        RGN_NONE = 2'd0,
        RGN_RAM  = 2'd1,
        RGN_MMIO = 2'd2
    } region_e;

    function automatic logic [31:0] status_word(input logic       empty,
                                                input logic       full,
                                                input logic       ovf,
                                                input logic [3:0] cnt);
        logic [31:0] w;
        w                    = '0;
        w[ST_EMPTY]          = empty;
        w[ST_FULL]           = full;
        w[ST_OVF]            = ovf;
        w[ST_CNT_LSB +: 4]   = cnt;
        return w;
    endfunction

endpackage

// File: rtl/mmio_tx_fifo.sv
// Console transmit FIFO: byte storage, wrapping pointers and occupancy count.
// A push into a full FIFO is only taken when a pop frees a slot the same cycle.
module mmio_tx_fifo #(
    parameter int TX_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [3:0] count,
    output logic [7:0] head
);

    localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;

    logic [7:0]    mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [3:0]    cnt;
    logic          pop_ok;
    logic          push_ok;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(TX_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt == 4'd0);
    assign full    = (cnt == 4'(TX_DEPTH));
    assign count   = cnt;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= 4'd0;
        end else begin
            if (push_ok) wr_ptr <= next_ptr(wr_ptr);
            if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 4'd1;
                2'b01:   cnt <= cnt - 4'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is data only; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data-port memory for the single-cycle RV32 core: byte-writable RAM with
// asynchronous read, plus an MMIO window (console TX FIFO, STATUS, CYCLE).
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE,
    parameter int          TX_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

    logic [31:0] ram [DEPTH];
    logic [AW-1:0] ram_idx;
    logic [1:0]    mmio_off;
    region_e       region;

    logic [31:0] cycle;
    logic        overflow;
    logic        push_req;
    logic        pop_req;
    logic        ovf_clr;
    logic        cyc_load;
    logic        fifo_full;
    logic        fifo_empty;
    logic [3:0]  fifo_count;
    logic [7:0]  fifo_head;

    assign ram_idx  = daddr[AW+1:2];
    assign mmio_off = daddr[3:2];

    // RAM takes priority should the MMIO window ever be placed inside it.
    always_comb begin
        region = RGN_NONE;
        if (daddr < RAM_BYTES)
            region = RGN_RAM;
        else if (daddr[31:4] == MMIO_BASE[31:4])
            region = RGN_MMIO;
    end

    assign push_req = (region == RGN_MMIO) && (mmio_off == OFF_TXDATA) && dwe[0];
    assign ovf_clr  = (region == RGN_MMIO) && (mmio_off == OFF_STATUS) && dwe[0] && dwdata[ST_OVF];
    assign cyc_load = (region == RGN_MMIO) && (mmio_off == OFF_CYCLE) && (dwe == 4'b1111);
    assign pop_req  = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (region == RGN_RAM) begin
            for (int i = 0; i < 4; i++) begin
                if (dwe[i]) ram[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
            end
        end
    end

    mmio_tx_fifo #(
        .TX_DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (dwdata[7:0]),
        .pop       (pop_req),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // tx_valid is purely registered state, so tx_ready cannot reach it.
    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (push_req && fifo_full && !pop_req) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cycle <= '0;
        else if (cyc_load)
            cycle <= dwdata;
        else
            cycle <= cycle + 32'd1;
    end

    always_comb begin
        drdata = '0;
        case (region)
            RGN_RAM: drdata = ram[ram_idx];
            RGN_MMIO: begin
                case (mmio_off)
                    OFF_STATUS: drdata = status_word(fifo_empty, fifo_full, overflow, fifo_count);
                    OFF_CYCLE:  drdata = cycle;
                    default:    drdata = '0;
                endcase
            end
            default: drdata = '0;
        endcase
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: a vector table of per-cycle bus accesses with expected
// drdata, a scoreboard queue modelling the console stream, and a reset sequence.
module tb_dmem_mmio;

    localparam int          DEPTH    = 1024;
    localparam int          TX_DEPTH = 8;
    localparam logic [31:0] MB       = 32'hFFFF_0000;
    localparam logic [31:0] A_TX     = MB;
    localparam logic [31:0] A_ST     = MB + 32'h4;
    localparam logic [31:0] A_CY     = MB + 32'h8;
    localparam logic [31:0] A_RSV    = MB + 32'hC;
    localparam logic [31:0] A_END    = 32'(4 * DEPTH);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dwdata = '0;
    logic [3:0]  dwe = '0;
    logic [31:0] drdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] sb[$];
    bit         mon_en = 1'b0;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic        rdy;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[$];

    dmem_mmio #(
        .DEPTH     (DEPTH),
        .MMIO_BASE (MB),
        .TX_DEPTH  (TX_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .daddr    (daddr),
        .dwdata   (dwdata),
        .dwe      (dwe),
        .drdata   (drdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic add(input string nm, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] w, input logic r, input logic c, input logic [31:0] e);
        vec_t v;
        v.name = nm; v.addr = a; v.wdata = d; v.we = w; v.rdy = r; v.chk = c; v.exp = e;
        vt.push_back(v);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w, input logic r);
        daddr = a; dwdata = d; dwe = w; tx_ready = r;
    endtask

    // Console scoreboard: checks the stream each cycle and models push acceptance.
    int  pre_size;
    bit  popping;
    always @(negedge clk) begin
        if (mon_en) begin
            pre_size = sb.size();
            popping  = (pre_size > 0) && tx_ready;
            chk("tx_valid", {31'b0, tx_valid}, {31'b0, (pre_size > 0)});
            chk("tx_data", {24'b0, tx_data}, (pre_size > 0) ? {24'b0, sb[0]} : 32'h0);
            if (popping) void'(sb.pop_front());
            if (daddr == A_TX && dwe[0] && (pre_size < TX_DEPTH || popping))
                sb.push_back(dwdata[7:0]);
        end
    end

    initial begin
        // Cycle k after release reads CYCLE == k unless reloaded.
        add("cyc0",      A_CY,   32'h0,        4'h0, 1'b0, 1'b1, 32'h0);
        add("cyc1",      A_CY,   32'h0,        4'h0, 1'b0, 1'b1, 32'h1);
        add("st_rst",    A_ST,   32'h0,        4'h0, 1'b0, 1'b1, 32'h1);
        add("sw_ram",    32'h10, 32'h11223344, 4'hF, 1'b0, 1'b0, 32'h0);
        add("sb_ram",    32'h10, 32'h00AA0000, 4'h4, 1'b0, 1'b1, 32'h11223344);
        add("ram_lane",  32'h10, 32'h0,        4'h0, 1'b0, 1'b1, 32'h11AA3344);
        add("ram_end",   A_END,  32'h0,        4'h0, 1'b0, 1'b1, 32'h0);
        add("hole_wr",   A_END,  32'hDEADBEEF, 4'hF, 1'b0, 1'b1, 32'h0);
        add("rsv_wr",    A_RSV,  32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 32'h0);
        add("st_idle",   A_ST,   32'h0,        4'h0, 1'b0, 1'b1, 32'h1);
        add("push41",    A_TX,   32'h41,       4'h1, 1'b0, 1'b1, 32'h0);
        add("push42",    A_TX,   32'h42,       4'h1, 1'b0, 1'b1, 32'h0);
        add("push43",    A_TX,   32'h43,       4'h1, 1'b0, 1'b1, 32'h0);
        add("st_3",      A_ST,   32'h0,        4'h0, 1'b0, 1'b1, 32'h30);
        add("st_3hold",  A_ST,   32'h0,        4'h0, 1'b0, 1'b1, 32'h30);
        add("drain3",    A_ST,   32'h0,        4'h0, 1'b1, 1'b1, 32'h30);
        add("drain2",    A_ST,   32'h0,        4'h0, 1'b1, 1'b1, 32'h20);
        add("drain1",    A_ST,   32'h0,        4'h0, 1'b1, 1'b1, 32'h10);
        add("drain0",    A_ST,   32'h0,        4'h0, 1'b1, 1'b1, 32'h1);
        for (int i = 0; i < 9; i++)
            add("push9", A_TX, 32'h50 + 32'(i), 4'h1, 1'b0, 1'b1, 32'h0);
        add("st_ovf",    A_ST,   32'h0,        4'h0, 1'b0, 1'b1, 32'h86);
        add("ovf_clr",   A_ST,   32'h4,        4'h1, 1'b0, 1'b1, 32'h86);
        add("st_full",   A_ST,   32'h0,        4'h0, 1'b0, 1'b1, 32'h82);
        add("push_fpop", A_TX,   32'h60,       4'h1, 1'b1, 1'b1, 32'h0);
        add("st_fpop",   A_ST,   32'h0,        4'h0, 1'b0, 1'b1, 32'h82);
        add("drain8",    A_ST,   32'h0,        4'h0, 1'b1, 1'b1, 32'h82);
        for (int i = 7; i >= 1; i--)
            add("drain", A_ST, 32'h0, 4'h0, 1'b1, 1'b1, {24'h0, 4'(i), 4'h0});
        add("drain_e",   A_ST,   32'h0,        4'h0, 1'b1, 1'b1, 32'h1);
        add("push_epop", A_TX,   32'h77,       4'h1, 1'b1, 1'b1, 32'h0);
        add("st_epop",   A_ST,   32'h0,        4'h0, 1'b0, 1'b1, 32'h10);
        add("pop77",     A_ST,   32'h0,        4'h0, 1'b1, 1'b1, 32'h10);
        add("st_e2",     A_ST,   32'h0,        4'h0, 1'b0, 1'b1, 32'h1);
        add("cyc_ld",    A_CY,   32'hFFFFFFFE, 4'hF, 1'b0, 1'b1, 32'(vt.size()));
        add("cyc_fe",    A_CY,   32'h0,        4'h0, 1'b0, 1'b1, 32'hFFFFFFFE);
        add("cyc_ff",    A_CY,   32'h0,        4'h0, 1'b0, 1'b1, 32'hFFFFFFFF);
        add("cyc_wrap",  A_CY,   32'h0,        4'h0, 1'b0, 1'b1, 32'h0);
        add("cyc_part",  A_CY,   32'h12345678, 4'h3, 1'b0, 1'b1, 32'h1);
        add("cyc_ign",   A_CY,   32'h0,        4'h0, 1'b0, 1'b1, 32'h2);

        // Reset state while reset is held.
        drive(A_ST, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        chk("rst_status", drdata, 32'h1);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
        daddr = A_CY;
        @(negedge clk);
        chk("rst_cycle", drdata, 32'h0);

        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                reset  = 1'b1;
                mon_en = 1'b1;
            end
            drive(vt[i].addr, vt[i].wdata, vt[i].we, vt[i].rdy);
            @(negedge clk);
            if (vt[i].chk) chk(vt[i].name, drdata, vt[i].exp);
        end

        // Half-fill the FIFO, then pull reset mid-cycle.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 drive(A_TX, 32'h90 + 32'(i), 4'h1, 1'b0);
        end
        @(posedge clk);
        #1 drive(A_ST, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        chk("half_status", drdata, 32'h40);
        mon_en = 1'b0;
        #2 reset = 1'b0;
        sb.delete();
        #1;
        chk("async_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("async_tx_data", {24'b0, tx_data}, 32'h0);
        chk("async_status", drdata, 32'h1);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        drive(A_ST, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        chk("post_status", drdata, 32'h1);
        @(posedge clk);
        #1 daddr = 32'h10;
        @(negedge clk);
        chk("post_ram", drdata, 32'h11AA3344);
        @(posedge clk);
        #1 daddr = A_CY;
        @(negedge clk);
        chk("post_cycle", drdata, 32'h2);

        @(posedge clk);
        #1 mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
